// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word and
// buffers up to two encoded entries for a ready/valid consumer.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  cls,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_illegal,
    output logic [15:0] enc_count
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} fifo_state_t;

    fifo_state_t state, state_next;
    logic        push, pop;
    logic [32:0] enc_p0;
    logic [31:0] head_instr_p1, tail_instr_p1;
    logic        head_ill_p1, tail_ill_p1;
    logic        unused_imm_hi;

    // Returns {illegal, word}. Misaligned branch/jump targets still encode,
    // with imm[0] simply dropped by the format.
    function automatic logic [32:0] encode(
        input logic [2:0]         c,
        input logic [2:0]         f3,
        input logic [6:0]         f7,
        input logic [4:0]         d,
        input logic [4:0]         s1,
        input logic [4:0]         s2,
        input logic signed [31:0] im
    );
        logic [31:0] w;
        logic        ill;
        ill = 1'b0;
        unique case (c)
            3'd0: w = {im[11:0], s1, f3, d, 7'b0000011};
            3'd1: w = {im[11:5], s2, s1, f3, im[4:0], 7'b0100011};
            3'd2: w = {f7, s2, s1, f3, d, 7'b0110011};
            3'd3: begin
                w   = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
                ill = im[0];
            end
            3'd4: begin
                w   = {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
                ill = im[0];
            end
            3'd5: w = {im[11:0], s1, 3'b000, d, 7'b1100111};
            3'd6: begin
                if (f3 == 3'b001 || f3 == 3'b101)
                    w = {f7, im[4:0], s1, f3, d, 7'b0010011};
                else
                    w = {im[11:0], s1, f3, d, 7'b0010011};
            end
            default: begin
                w   = 32'h0000_0013;
                ill = 1'b1;
            end
        endcase
        return {ill, w};
    endfunction

    assign unused_imm_hi = ^imm[31:21];

    // Stage p0: combinational encode of the incoming request
    assign enc_p0 = encode(cls, funct3, funct7, rd, rs1, rs2, $signed(imm));
    assign push   = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)
                    state_next = FULL;
                else if (pop && !push)
                    state_next = EMPTY;
            end
            FULL:  if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = !rst && (state != FULL);
        out_valid = (state != EMPTY);
    end

    // Stage p1: two-entry buffer, head always presented on the output
    always_ff @(posedge clk) begin
        if (rst) begin
            head_instr_p1 <= '0;
            head_ill_p1   <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: if (push) {head_ill_p1, head_instr_p1} <= enc_p0;
                ONE: begin
                    if (push && pop)
                        {head_ill_p1, head_instr_p1} <= enc_p0;
                    else if (push)
                        {tail_ill_p1, tail_instr_p1} <= enc_p0;
                end
                FULL: begin
                    if (pop) begin
                        head_instr_p1 <= tail_instr_p1;
                        head_ill_p1   <= tail_ill_p1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            enc_count <= '0;
        else if (pop)
            enc_count <= enc_count + 16'd1;
    end

    assign out_instr   = head_instr_p1;
    assign out_illegal = head_ill_p1;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus random traffic checked
// against a queue-based reference built from the RV32I field layouts.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [2:0]  cls, funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, out_instr;
    logic [15:0] enc_count;

    int          checks = 0;
    int          failures = 0;
    logic [32:0] q[$];
    logic [15:0] cnt_m = '0;

    instr_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cls(cls), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_illegal(out_illegal), .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint p2(input int n);
        return longint'(1) << n;
    endfunction

    function automatic longint fld(input longint x, input int hi, input int lo);
        return (x / p2(lo)) % p2(hi - lo + 1);
    endfunction

    // Word assembled as a sum of fields scaled to their bit positions.
    function automatic logic [32:0] ref_enc(input logic [2:0] c, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [4:0] d,
                                            input logic [4:0] s1, input logic [4:0] s2,
                                            input logic [31:0] im);
        longint w, i, lf3, lf7, ld, ls1, ls2;
        logic [63:0] wv;
        bit ill;
        i = longint'({32'd0, im});
        lf3 = longint'(f3); lf7 = longint'(f7); ld = longint'(d);
        ls1 = longint'(s1); ls2 = longint'(s2);
        ill = 0;
        case (c)
            3'd0: w = 3 + ld*p2(7) + lf3*p2(12) + ls1*p2(15) + fld(i,11,0)*p2(20);
            3'd1: w = 35 + fld(i,4,0)*p2(7) + lf3*p2(12) + ls1*p2(15) + ls2*p2(20) + fld(i,11,5)*p2(25);
            3'd2: w = 51 + ld*p2(7) + lf3*p2(12) + ls1*p2(15) + ls2*p2(20) + lf7*p2(25);
            3'd3: begin
                w = 99 + fld(i,11,11)*p2(7) + fld(i,4,1)*p2(8) + lf3*p2(12) + ls1*p2(15)
                    + ls2*p2(20) + fld(i,10,5)*p2(25) + fld(i,12,12)*p2(31);
                ill = (i % 2) == 1;
            end
            3'd4: begin
                w = 111 + ld*p2(7) + fld(i,19,12)*p2(12) + fld(i,11,11)*p2(20)
                    + fld(i,10,1)*p2(21) + fld(i,20,20)*p2(31);
                ill = (i % 2) == 1;
            end
            3'd5: w = 103 + ld*p2(7) + ls1*p2(15) + fld(i,11,0)*p2(20);
            3'd6: begin
                if (f3 == 3'd1 || f3 == 3'd5)
                    w = 19 + ld*p2(7) + lf3*p2(12) + ls1*p2(15) + fld(i,4,0)*p2(20) + lf7*p2(25);
                else
                    w = 19 + ld*p2(7) + lf3*p2(12) + ls1*p2(15) + fld(i,11,0)*p2(20);
            end
            default: begin
                w = 19;
                ill = 1;
            end
        endcase
        wv = w;
        return {ill, wv[31:0]};
    endfunction

    task automatic set_req(input logic v, input logic [2:0] c, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [31:0] im);
        in_valid = v; cls = c; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    task automatic cycle(input bit chk);
        bit push, pop;
        logic [32:0] exp_word;
        if (chk) begin
            check("in_ready", in_ready, q.size() < 2);
            check("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                check("out_instr", out_instr, q[0][31:0]);
                check("out_illegal", out_illegal, q[0][32]);
            end
            check("enc_count", enc_count, cnt_m);
        end
        push = in_valid && (q.size() < 2);
        pop  = out_ready && (q.size() > 0);
        exp_word = ref_enc(cls, funct3, funct7, rd, rs1, rs2, imm);
        @(posedge clk);
        #1;
        if (pop) begin
            void'(q.pop_front());
            cnt_m++;
        end
        if (push) q.push_back(exp_word);
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0;
        set_req(1'b0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_illegal", out_illegal, 1'b0);
        check("rst_enc_count", enc_count, 16'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // LOAD x5, 4(x2)
        out_ready = 1'b1;
        set_req(1'b1, 3'd0, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0, 32'd4);
        cycle(1);
        in_valid = 1'b0;
        check("load_valid", out_valid, 1'b1);
        check("load_word", out_instr, 32'h00412283);
        check("load_illegal", out_illegal, 1'b0);
        cycle(1);
        check("load_count", enc_count, 16'd1);

        set_req(1'b1, 3'd2, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        cycle(1);
        in_valid = 1'b0;
        check("rtype_word", out_instr, 32'h002081B3);
        cycle(1);

        set_req(1'b1, 3'd4, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
        cycle(1);
        in_valid = 1'b0;
        check("jal_word", out_instr, 32'h008000EF);
        check("jal_illegal", out_illegal, 1'b0);
        cycle(1);
        set_req(1'b1, 3'd4, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd9);
        cycle(1);
        in_valid = 1'b0;
        check("jal_odd_illegal", out_illegal, 1'b1);
        cycle(1);

        set_req(1'b1, 3'd7, 3'd5, 7'h55, 5'd9, 5'd9, 5'd9, 32'hFFFF_FFFF);
        cycle(1);
        in_valid = 1'b0;
        check("rsvd_word", out_instr, 32'h00000013);
        check("rsvd_illegal", out_illegal, 1'b1);
        cycle(1);

        // Back-pressure: third request held until a slot frees
        out_ready = 1'b0;
        set_req(1'b1, 3'd1, 3'b010, 7'd0, 5'd0, 5'd3, 5'd4, 32'hFFFF_FFF8);
        cycle(1);
        set_req(1'b1, 3'd3, 3'b001, 7'd0, 5'd0, 5'd6, 5'd7, 32'hFFFF_FFF0);
        cycle(1);
        set_req(1'b1, 3'd6, 3'b101, 7'h20, 5'd8, 5'd9, 5'd0, 32'd3);
        check("full_in_ready", in_ready, 1'b0);
        cycle(1);
        cycle(1);
        out_ready = 1'b1;
        cycle(1);
        check("third_waits", q.size(), 1);
        cycle(1);
        in_valid = 1'b0;
        repeat (3) cycle(1);

        // Reset while full, with a push and pop pending
        out_ready = 1'b0;
        set_req(1'b1, 3'd5, 3'b111, 7'd0, 5'd1, 5'd2, 5'd0, 32'd100);
        cycle(1);
        cycle(1);
        check("prefull_count", q.size(), 2);
        rst = 1'b1; out_ready = 1'b1;
        #1;
        check("rst_hold_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        check("rst_full_out_valid", out_valid, 1'b0);
        check("rst_full_enc_count", enc_count, 16'd0);
        check("rst_full_instr", out_instr, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        q.delete(); cnt_m = '0;
        #1;
        check("rst_full_in_ready", in_ready, 1'b1);

        for (int n = 0; n < 300; n++) begin
            set_req(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 3'($urandom),
                    7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle(1);
        end

        // Stream 65535 handshakes so the counter reaches its wrap point
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); cnt_m = '0;
        out_ready = 1'b1;
        set_req(1'b1, 3'd7, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        for (int n = 0; n < 65536; n++) cycle(0);
        in_valid = 1'b0;
        check("count_ffff", enc_count, 16'hFFFF);
        cycle(1);
        check("count_wrap", enc_count, 16'h0000);
        cycle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL provide port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide port: in_valid  input  1  request carries valid instruction fields.
REQ-004 SHALL provide port: in_ready  output  1  encoder can accept a request this cycle.
REQ-005 SHALL provide port: cls  input  3  class: 0 LOAD, 1 STORE, 2 R-TYPE, 3 BRANCH, 4 JAL, 5 JALR, 6 I-ALU, 7 reserved.
REQ-006 SHALL provide ports: funct3 input 3; funct7 input 7; rd, rs1, rs2 input 5 each; imm input 32 (signed byte offset / immediate).
REQ-007 SHALL provide port: out_valid  output  1  out_instr holds an encoded RV32I word.
REQ-008 SHALL provide port: out_ready  input  1  consumer accepts out_instr this cycle.
REQ-009 SHALL provide port: out_instr  output  32  encoded instruction word.
REQ-010 SHALL provide port: out_illegal  output  1  entry at head was illegal/misaligned; qualified by out_valid.
REQ-011 SHALL provide port: enc_count  output  16  count of completed output handshakes.

Function
REQ-012 SHALL accept a request on a rising edge with in_valid && in_ready; SHALL emit it on out_instr with out_valid high from the next cycle (latency 1).
REQ-013 SHALL complete an output transfer on a rising edge with out_valid && out_ready.
REQ-014 SHALL buffer up to 2 encoded entries in a FIFO with states EMPTY, ONE, FULL; push-only advances EMPTY->ONE->FULL, pop-only retreats FULL->ONE->EMPTY, simultaneous push+pop in ONE stays ONE.
REQ-015 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL and during rst; requests with in_ready low are ignored.
REQ-016 SHALL preserve request order; out_instr/out_illegal SHALL be held stable while out_valid && !out_ready.
REQ-017 SHALL encode LOAD (0000011), JALR (1100111, funct3 forced 000), I-ALU (0010011) as I-type: imm[11:0] | rs1 | funct3 | rd | opcode.
REQ-018 SHALL encode I-ALU with funct3 001/101 as shift: funct7 | imm[4:0] | rs1 | funct3 | rd | opcode.
REQ-019 SHALL encode STORE (0100011) as S-type: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
REQ-020 SHALL encode R-TYPE (0110011): funct7 | rs2 | rs1 | funct3 | rd | opcode.
REQ-021 SHALL encode BRANCH (1100011) as B-type: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
REQ-022 SHALL encode JAL (1101111) as J-type: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode.
REQ-023 SHALL set out_illegal for BRANCH/JAL when imm[0]=1 (word still encoded, imm[0] dropped).
REQ-024 SHALL, for cls=7, emit 32'h00000013 (NOP) with out_illegal=1.
REQ-025 SHALL ignore unused fields per class (e.g. rd for STORE/BRANCH).
REQ-026 SHALL increment enc_count by 1 per output handshake, wrapping 16'hFFFF -> 16'h0000.

Reset
REQ-027 SHALL, while rst is high at a rising edge, set FIFO to EMPTY, out_valid=0, out_instr=0, out_illegal=0, enc_count=0, discarding buffered entries.
REQ-028 SHALL hold in_ready=0 while rst is high; in_ready=1 on the first cycle after rst deasserts.
REQ-029 SHALL give rst priority over simultaneous push/pop in the same cycle.

Verification
REQ-030 LOAD rd=5 rs1=2 funct3=010 imm=4, out_ready=1 -> next cycle out_valid=1, out_instr=32'h00412283, out_illegal=0, enc_count=1.
REQ-031 R-TYPE rd=3 rs1=1 rs2=2 funct3=000 funct7=0 -> out_instr=32'h002081B3.
REQ-032 JAL rd=1 imm=8 -> out_instr=32'h008000EF; JAL imm=9 -> out_illegal=1.
REQ-033 out_ready=0, three back-to-back requests -> in_ready low after two; release out_ready -> both words out in order, third accepted after one pop.
REQ-034 cls=7 -> out_instr=32'h00000013, out_illegal=1.
REQ-035 FIFO FULL, rst high one cycle -> out_valid=0, enc_count=0, in_ready=1 next cycle; enc_count preloaded to 16'hFFFF wraps to 0 on next handshake.
